wb_rfid_reader: RTL and testbench

- Wishbone slave that sits on the external RFID serial line in place of a generic UART.
- Deserialises 8N1 bytes from a 125 kHz reader module and parses its fixed ASCII frame: STX 0x02, 10 hex chars (2 version + 8 tag), 2 hex checksum chars, ETX 0x03.
- Validates the frame and latches the decoded tag into CPU-readable registers.
- Raises an optional interrupt, so firmware never parses bytes itself.

---
 rtl/wb_rfid_reader_pkg.sv | 35 +++
 rtl/wb_rfid_reader_uart_rx.sv | 108 ++++++++++
 rtl/wb_rfid_reader.sv | 200 ++++++++++++++++++++
 tb/tb_wb_rfid_reader.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rfid_reader_pkg.sv
// Shared definitions for the Wishbone RFID reader: register map, STATUS bit
// positions, frame delimiters, parser state encoding and ASCII hex decoding.
package wb_rfid_reader_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_TAG_LO = 2'd1;
    localparam logic [1:0] REG_TAG_HI = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int ST_VALID     = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAME_ERR = 2;

    localparam logic [7:0] ASCII_STX = 8'h02;
    localparam logic [7:0] ASCII_ETX = 8'h03;

    typedef enum logic [1:0] {
        P_IDLE  = 2'd0,
        P_DATA  = 2'd1,
        P_CKSUM = 2'd2,
        P_ETX   = 2'd3
    } parse_state_t;

    // Returns {is_hex, nibble}; letters map via low nibble + 9 ('A'/'a' -> 0xA).
    function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
        logic [4:0] res;
        res = 5'h00;
        if (c >= 8'h30 && c <= 8'h39)
            res = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            res = {1'b1, c[3:0] + 4'd9};
        return res;
    endfunction

endpackage

// File: rtl/wb_rfid_reader_uart_rx.sv
// 8N1 serial receiver for the RFID reader line: 2-FF synchroniser, half-bit
// start confirmation, centre sampling, 1-cycle byte strobe and stop-error pulse.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronised line
// RX_START | half-bit wait, then confirm the start bit is still low
// RX_DATA  | sampling 8 data bits LSB first at bit centres
// RX_STOP  | sampling the stop bit; 1 -> byte strobe, 0 -> stop error
module rfid_uart_rx #(
    parameter int clk_freq = 100000000,
    parameter int baud     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       stop_err
);
    localparam int BIT_CYC  = clk_freq / baud;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = $clog2(BIT_CYC);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t       state;
    logic            sync_1, sync_2, rx_prev;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    // Bring the asynchronous line into clk domain and keep one bit of history.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= rxd;
            sync_2  <= sync_1;
            rx_prev <= sync_2;
        end
    end

    // Bit timing uses a down-counter reloaded per bit; action at terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            data     <= '0;
            valid    <= 1'b0;
            stop_err <= 1'b0;
        end else begin
            valid    <= 1'b0;
            stop_err <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !sync_2) begin
                        state <= RX_START;
                        cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!sync_2) begin
                        state   <= RX_DATA;
                        cnt     <= BIT_LAST;
                        bit_idx <= '0;
                    end else begin
                        state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg <= {sync_2, shreg[7:1]};
                        cnt   <= BIT_LAST;
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (sync_2) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end else begin
                            stop_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_rfid_reader.sv
// Wishbone RFID reader: parses STX + 10 hex + 2 hex checksum + ETX frames and
// latches the tag. Optional macro RFID_DEDUP_EN suppresses repeats of the last
// accepted tag arriving within 500 ms of the previous copy.
//
// state   | meaning
// P_IDLE  | hunting for STX, all other bytes ignored
// P_DATA  | collecting 10 data nibbles (idx 0..9), XOR per completed byte
// P_CKSUM | collecting 2 checksum nibbles (idx 0..1)
// P_ETX   | expecting ETX; checksum compared here, back to idle after
module wb_rfid_reader
    import wb_rfid_reader_pkg::*;
#(
    parameter int clk_freq = 100000000,
    parameter int baud     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    input  logic        rfid_rxd,
    output logic        intr
);
    logic [7:0]   rx_data;
    logic         rx_valid, rx_stop_err;
    parse_state_t pstate;
    logic [3:0]   idx;
    logic [39:0]  data_sr;
    logic [7:0]   cksum_rx, xor_acc;
    logic [4:0]   nib_dec;
    logic         hex_ok, frame_good, frame_bad, accept;
    logic [2:0]   status, w1c, status_nxt;
    logic [31:0]  tag_lo, rd_mux;
    logic [7:0]   tag_hi;
    logic         irq_en, bus_hit, wr_en, rd_en;
    logic [1:0]   reg_sel;
    logic         unused_bits;

    rfid_uart_rx #(.clk_freq(clk_freq), .baud(baud)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rfid_rxd),
        .data     (rx_data),
        .valid    (rx_valid),
        .stop_err (rx_stop_err)
    );

    assign nib_dec    = ascii_to_nibble(rx_data);
    assign hex_ok     = nib_dec[4];
    assign frame_good = rx_valid && (pstate == P_ETX) && (rx_data == ASCII_ETX)
                        && (cksum_rx == xor_acc);
    assign frame_bad  = rx_stop_err
                        || (rx_valid && (pstate == P_DATA || pstate == P_CKSUM) && !hex_ok)
                        || (rx_valid && (pstate == P_ETX) && !frame_good);

    // Frame parser; advances only on received bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            pstate   <= P_IDLE;
            idx      <= '0;
            data_sr  <= '0;
            cksum_rx <= '0;
            xor_acc  <= '0;
        end else if (rx_valid) begin
            case (pstate)
                P_IDLE: begin
                    if (rx_data == ASCII_STX) begin
                        pstate  <= P_DATA;
                        idx     <= '0;
                        xor_acc <= '0;
                    end
                end
                P_DATA: begin
                    if (hex_ok) begin
                        data_sr <= {data_sr[35:0], nib_dec[3:0]};
                        if (idx[0])
                            xor_acc <= xor_acc ^ {data_sr[3:0], nib_dec[3:0]};
                        if (idx == 4'd9) begin
                            pstate <= P_CKSUM;
                            idx    <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (rx_data == ASCII_STX) begin
                        idx     <= '0;
                        xor_acc <= '0;
                    end else begin
                        pstate <= P_IDLE;
                    end
                end
                P_CKSUM: begin
                    if (hex_ok) begin
                        cksum_rx <= {cksum_rx[3:0], nib_dec[3:0]};
                        if (idx == 4'd1)
                            pstate <= P_ETX;
                        else
                            idx <= idx + 1'b1;
                    end else if (rx_data == ASCII_STX) begin
                        pstate  <= P_DATA;
                        idx     <= '0;
                        xor_acc <= '0;
                    end else begin
                        pstate <= P_IDLE;
                    end
                end
                default: pstate <= P_IDLE;
            endcase
        end
    end

`ifdef RFID_DEDUP_EN
    localparam logic [31:0] DEDUP_LAST = 32'(clk_freq / 2 - 1);
    logic [39:0] last_tag;
    logic [31:0] dedup_cnt;
    logic        dedup_live;

    assign accept = frame_good && !(dedup_live && (data_sr == last_tag));

    // Repeat window: every good frame re-arms it and becomes the reference value.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_tag   <= '0;
            dedup_cnt  <= '0;
            dedup_live <= 1'b0;
        end else if (frame_good) begin
            last_tag   <= data_sr;
            dedup_cnt  <= DEDUP_LAST;
            dedup_live <= 1'b1;
        end else if (dedup_live) begin
            if (dedup_cnt == '0)
                dedup_live <= 1'b0;
            else
                dedup_cnt <= dedup_cnt - 1'b1;
        end
    end
`else
    assign accept = frame_good;
`endif

    assign reg_sel     = wb_adr_i[3:2];
    assign bus_hit     = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr_en       = bus_hit & wb_we_i;
    assign rd_en       = bus_hit & ~wb_we_i;
    assign w1c         = (wr_en && reg_sel == REG_STATUS) ? wb_dat_i[2:0] : 3'b000;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:3]};

    // Status next value: hardware set wins over a simultaneous W1C.
    always_comb begin
        status_nxt = status & ~w1c;
        if (accept) begin
            status_nxt[ST_VALID] = 1'b1;
            if (status[ST_VALID] && !w1c[ST_VALID])
                status_nxt[ST_OVERRUN] = 1'b1;
        end
        if (frame_bad)
            status_nxt[ST_FRAME_ERR] = 1'b1;
    end

    // Read data mux by word address.
    always_comb begin
        rd_mux = 32'h0;
        case (reg_sel)
            REG_STATUS: rd_mux = {29'h0, status};
            REG_TAG_LO: rd_mux = tag_lo;
            REG_TAG_HI: rd_mux = {24'h0, tag_hi};
            REG_CTRL:   rd_mux = {31'h0, irq_en};
            default:    rd_mux = 32'h0;
        endcase
    end

    // Register file, bus handshake and interrupt output.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            status   <= '0;
            tag_lo   <= '0;
            tag_hi   <= '0;
            irq_en   <= 1'b0;
            intr     <= 1'b0;
        end else begin
            wb_ack_o <= bus_hit;
            wb_dat_o <= rd_en ? rd_mux : 32'h0;
            status   <= status_nxt;
            if (wr_en && reg_sel == REG_CTRL)
                irq_en <= wb_dat_i[0];
            if (accept) begin
                tag_hi <= data_sr[39:32];
                tag_lo <= data_sr[31:0];
            end
            intr <= irq_en & status[ST_VALID];
        end
    end

endmodule

// File: tb/tb_wb_rfid_reader.sv
// Directed bench for wb_rfid_reader at 1 MHz / 100 kbaud (10 clocks per bit).
module tb_wb_rfid_reader;
    import wb_rfid_reader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i, wb_cyc_i, wb_we_i, wb_ack_o;
    logic        rfid_rxd, intr;

    int n_checks = 0;
    int n_fail   = 0;

    wb_rfid_reader #(.clk_freq(1000000), .baud(100000)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_sel_i (wb_sel_i),
        .wb_stb_i (wb_stb_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_we_i  (wb_we_i),
        .wb_ack_o (wb_ack_o),
        .rfid_rxd (rfid_rxd),
        .intr     (intr)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rfid_rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rfid_rxd = b[i];
            repeat (10) @(negedge clk);
        end
        rfid_rxd = stop_bit;
        repeat (10) @(negedge clk);
        rfid_rxd = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i], 1'b1);
    endtask

    task automatic send_head(input string body, input string ck);
        send_byte(ASCII_STX, 1'b1);
        send_str(body);
        send_str(ck);
    endtask

    task automatic send_frame(input string body, input string ck);
        send_head(body, ck);
        send_byte(ASCII_ETX, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rfid_rxd = 1'b1;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] ra, output logic [31:0] rd);
        int t;
        @(negedge clk);
        wb_adr_i = {28'h0, ra, 2'b00};
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (wb_ack_o !== 1'b1 && t < 4);
        rd = wb_dat_o;
        if (wb_ack_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL read_ack_timeout: ack=%b required 1", wb_ack_o);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] ra, input logic [31:0] wd);
        int t;
        @(negedge clk);
        wb_adr_i = {28'h0, ra, 2'b00};
        wb_dat_i = wd;
        wb_we_i  = 1'b1;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (wb_ack_o !== 1'b1 && t < 4);
        if (wb_ack_o !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL write_ack_timeout: ack=%b required 1", wb_ack_o);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    // Frame 1: bytes 01 00 AB CD EF, XOR = 0x88.
    task automatic test_good_frame();
        logic [31:0] rd;
        int t;
        do_reset();
        wb_write(REG_CTRL, 32'h1);
        send_head("0100ABCDEF", "88");
        fork
            send_byte(ASCII_ETX, 1'b1);
            begin
                t = 0;
                while (dut.rx_valid !== 1'b1 && t < 300) begin
                    @(negedge clk);
                    t++;
                end
                n_checks++;
                if (t >= 300) begin
                    n_fail++;
                    $display("FAIL good_etx_timeout: waited %0d cycles, required < 300", t);
                end
                n_checks++;
                if (intr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL good_intr_before: got %b required 0", intr);
                end
                @(negedge clk);
                n_checks++;
                if (intr !== 1'b0) begin
                    n_fail++;
                    $display("FAIL good_intr_lag: got %b required 0", intr);
                end
                @(negedge clk);
                n_checks++;
                if (intr !== 1'b1) begin
                    n_fail++;
                    $display("FAIL good_intr_rise: got %b required 1", intr);
                end
            end
        join
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL good_status: got %h required %h", rd, 32'h1);
        end
        wb_read(REG_TAG_LO, rd);
        n_checks++;
        if (rd !== 32'h00ABCDEF) begin
            n_fail++;
            $display("FAIL good_tag_lo: got %h required %h", rd, 32'h00ABCDEF);
        end
        wb_read(REG_TAG_HI, rd);
        n_checks++;
        if (rd !== 32'h01) begin
            n_fail++;
            $display("FAIL good_tag_hi: got %h required %h", rd, 32'h01);
        end
    endtask

    // Starts from the dirty state left by test_good_frame; also covers a mid-frame reset.
    task automatic test_reset();
        logic [31:0] rd;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || intr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b dat=%h intr=%b required 0/0/0", wb_ack_o, wb_dat_o, intr);
        end
        reset = 1'b0;
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %h required 0", rd);
        end
        wb_read(REG_TAG_LO, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_tag_lo: got %h required 0", rd);
        end
        wb_read(REG_TAG_HI, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_tag_hi: got %h required 0", rd);
        end
        wb_read(REG_CTRL, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h required 0", rd);
        end
        send_byte(ASCII_STX, 1'b1);
        send_str("01");
        do_reset();
        send_str("00ABCDEF88");
        send_byte(ASCII_ETX, 1'b1);
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_midframe_status: got %h required 0", rd);
        end
    endtask

    task automatic test_bad_cksum();
        logic [31:0] rd;
        do_reset();
        send_frame("0100ABCDEF", "89");
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h4) begin
            n_fail++;
            $display("FAIL badck_status: got %h required %h", rd, 32'h4);
        end
        wb_read(REG_TAG_LO, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL badck_tag_lo: got %h required 0", rd);
        end
        wb_read(REG_TAG_HI, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL badck_tag_hi: got %h required 0", rd);
        end
        wb_write(REG_STATUS, 32'h4);
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL badck_w1c: got %h required 0", rd);
        end
    endtask

    // Second frame bytes 02 12 34 56 78: XOR = 0x0A.
    task automatic test_back_to_back();
        logic [31:0] rd;
        do_reset();
        send_frame("0100ABCDEF", "88");
        send_frame("0212345678", "0A");
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h3) begin
            n_fail++;
            $display("FAIL b2b_status: got %h required %h", rd, 32'h3);
        end
        wb_read(REG_TAG_LO, rd);
        n_checks++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL b2b_tag_lo: got %h required %h", rd, 32'h12345678);
        end
        wb_read(REG_TAG_HI, rd);
        n_checks++;
        if (rd !== 32'h02) begin
            n_fail++;
            $display("FAIL b2b_tag_hi: got %h required %h", rd, 32'h02);
        end
    endtask

    task automatic test_restart();
        logic [31:0] rd;
        do_reset();
        send_byte(ASCII_STX, 1'b1);
        send_str("0100");
        send_frame("0212345678", "0A");
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h5) begin
            n_fail++;
            $display("FAIL restart_status: got %h required %h", rd, 32'h5);
        end
        wb_read(REG_TAG_LO, rd);
        n_checks++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL restart_tag_lo: got %h required %h", rd, 32'h12345678);
        end
    endtask

    task automatic test_bus();
        logic [31:0] rd;
        int t;
        do_reset();
        wb_write(REG_CTRL, 32'h1);
        @(negedge clk);
        n_checks++;
        if (wb_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL bus_idle_dat: got %h required 0", wb_dat_o);
        end
        wb_adr_i = {28'h0, REG_CTRL, 2'b00};
        wb_we_i  = 1'b0;
        wb_stb_i = 1'b1;
        wb_cyc_i = 1'b1;
        n_checks++;
        if (wb_ack_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bus_ack_early: got %b required 0", wb_ack_o);
        end
        @(negedge clk);
        n_checks++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1) begin
            n_fail++;
            $display("FAIL bus_ack_rise: ack=%b dat=%h required 1/00000001", wb_ack_o, wb_dat_o);
        end
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
            n_fail++;
            $display("FAIL bus_ack_fall: ack=%b dat=%h required 0/0", wb_ack_o, wb_dat_o);
        end
        send_frame("0100ABCDEF", "88");
        send_head("0212345678", "0A");
        fork
            send_byte(ASCII_ETX, 1'b1);
            begin
                t = 0;
                while (dut.rx_valid !== 1'b1 && t < 300) begin
                    @(negedge clk);
                    t++;
                end
                n_checks++;
                if (t >= 300) begin
                    n_fail++;
                    $display("FAIL bus_etx_timeout: waited %0d cycles, required < 300", t);
                end
                wb_adr_i = {28'h0, REG_STATUS, 2'b00};
                wb_dat_i = 32'h1;
                wb_we_i  = 1'b1;
                wb_stb_i = 1'b1;
                wb_cyc_i = 1'b1;
                @(negedge clk);
                wb_stb_i = 1'b0;
                wb_cyc_i = 1'b0;
                wb_we_i  = 1'b0;
            end
        join
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL bus_set_wins: got %h required %h", rd, 32'h1);
        end
        wb_read(REG_TAG_LO, rd);
        n_checks++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL bus_tag_lo: got %h required %h", rd, 32'h12345678);
        end
    endtask

    // 'A' sent with a low stop bit is dropped, leaving ETX to land in the checksum phase.
    task automatic test_stop_err();
        logic [31:0] rd;
        logic [31:0] exp_rep;
        do_reset();
        send_byte(ASCII_STX, 1'b1);
        send_str("0100");
        send_byte(8'h41, 1'b0);
        send_str("BCDEF88");
        send_byte(ASCII_ETX, 1'b1);
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== 32'h4) begin
            n_fail++;
            $display("FAIL stoperr_status: got %h required %h", rd, 32'h4);
        end
        wb_read(REG_TAG_LO, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL stoperr_tag_lo: got %h required 0", rd);
        end
        do_reset();
        send_frame("0100ABCDEF", "88");
        wb_write(REG_STATUS, 32'h1);
        send_frame("0100abcdef", "88");
`ifdef RFID_DEDUP_EN
        exp_rep = 32'h0;
`else
        exp_rep = 32'h1;
`endif
        wb_read(REG_STATUS, rd);
        n_checks++;
        if (rd !== exp_rep) begin
            n_fail++;
            $display("FAIL repeat_status: got %h required %h", rd, exp_rep);
        end
        wb_read(REG_TAG_LO, rd);
        n_checks++;
        if (rd !== 32'h00ABCDEF) begin
            n_fail++;
            $display("FAIL repeat_tag_lo: got %h required %h", rd, 32'h00ABCDEF);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rfid_rxd = 1'b1;
        wb_adr_i = 32'h0;
        wb_dat_i = 32'h0;
        wb_sel_i = 4'hF;
        wb_stb_i = 1'b0;
        wb_cyc_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_good_frame();
        test_reset();
        test_bad_cksum();
        test_back_to_back();
        test_restart();
        test_bus();
        test_stop_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
